// File: rtl/apb4_reg_slave.sv
// APB4 register-file slave: NUM_REGS registers with byte strobes, optional wait
// states, RO/privilege checks and a per-register hardware update port.

module apb4_reg_slave_cell #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST        = '0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_apb_we,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  input  logic [DATA_WIDTH-1:0]   i_apb_data,
  input  logic                    i_hw_we,
  input  logic [DATA_WIDTH-1:0]   i_hw_data,
  output logic [DATA_WIDTH-1:0]   o_q
);
  localparam int NB = DATA_WIDTH/8;

  logic [DATA_WIDTH-1:0] r_q;

  // APB owns the strobed bytes; hardware update fills in the rest on a shared edge
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_q <= RST;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (i_apb_we && i_strb[b])
          r_q[b*8 +: 8] <= i_apb_data[b*8 +: 8];
        else if (i_hw_we)
          r_q[b*8 +: 8] <= i_hw_data[b*8 +: 8];
      end
    end
  end

  assign o_q = r_q;
endmodule

module apb4_reg_slave #(
  parameter int                              ADDR_WIDTH  = 32,
  parameter int                              DATA_WIDTH  = 32,
  parameter int                              NUM_REGS    = 16,
  parameter int                              WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]             RO_MASK     = '0,
  parameter bit                              PRIV_ONLY   = 1'b0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL   = '0
) (
  input  logic                           pclk,
  input  logic                           presetn,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [DATA_WIDTH-1:0]          pwdata,
  input  logic [DATA_WIDTH/8-1:0]        pstrb,
  input  logic [2:0]                     pprot,
  output logic                           pready,
  output logic [DATA_WIDTH-1:0]          prdata,
  output logic                           pslverr,
  input  logic [NUM_REGS-1:0]            hw_we,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int NB = DATA_WIDTH/8;
  localparam int SW = $clog2(NB);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH:0]   SPAN     = (ADDR_WIDTH+1)'(NUM_REGS*NB);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(NB-1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t                               r_state;
  logic [3:0]                           r_cnt;
  logic [NUM_REGS-1:0]                  r_wr_pulse;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  w_q;
  logic [IW-1:0]                        w_idx;
  logic                                 w_err, w_end, w_commit;
  logic                                 w_unused;

  assign w_unused = ^pprot[2:1];
  assign w_idx    = paddr[SW +: IW];

  assign w_err = ({1'b0, paddr} >= SPAN)
              || ((paddr & LOW_MASK) != '0)
              || (pwrite && RO_MASK[w_idx])
              || (PRIV_ONLY && !pprot[0]);

  assign w_end    = (r_state == S_ACCESS) && psel && penable && (r_cnt == 4'd0);
  assign pready   = presetn && w_end;
  assign pslverr  = pready && w_err;
  assign prdata   = (pready && !pwrite && !w_err) ? w_q[w_idx] : '0;
  assign w_commit = pready && pwrite && !w_err;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_commit ? (NUM_REGS'(1) << w_idx) : '0;
      case (r_state)
        S_IDLE: begin
          if (psel && !penable) begin
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!psel) begin
            r_state <= S_IDLE;
          end else if (!penable) begin
            // fresh setup without a completed access: restart the wait count
            r_cnt <= 4'(WAIT_STATES);
          end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_pulse = r_wr_pulse;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    apb4_reg_slave_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .RST        (RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .i_clk      (pclk),
      .i_rst_n    (presetn),
      .i_apb_we   (w_commit && (w_idx == IW'(i))),
      .i_strb     (pstrb),
      .i_apb_data (pwdata),
      .i_hw_we    (hw_we[i]),
      .i_hw_data  (hw_wdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .o_q        (w_q[i])
    );
  end

  assign reg_q = w_q;
endmodule

// File: tb/tb_apb4_reg_slave.sv
// Directed bench for apb4_reg_slave: three instances cover zero/two/three wait
// states, RO and privilege errors, strobes, hardware updates and reset.

module tb_apb4_reg_slave;
  localparam logic [511:0] RV_A = (512'h5555AAAA << (5*32)) | 512'h0BADF00D;
  localparam logic [511:0] RV_B = 512'hCAFEF00D;
  localparam logic [511:0] RV_C = 512'h00C0FFEE << 32;

  logic         pclk = 1'b0;
  logic [2:0]   rst_n, psel;
  logic         penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic [15:0]  hw_we_v [3];
  logic [511:0] hw_wdata;
  logic         pready_v [3];
  logic         pslverr_v [3];
  logic [31:0]  prdata_v [3];
  logic [511:0] regq_v [3];
  logic [15:0]  wrp_v [3];
  int           n_chk = 0;
  int           n_err = 0;

  always #5 pclk = ~pclk;

  apb4_reg_slave #(.WAIT_STATES(0), .RO_MASK(16'h0020), .RESET_VAL(RV_A)) u_dut_a (
    .pclk(pclk), .presetn(rst_n[0]), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_v[0]), .prdata(prdata_v[0]), .pslverr(pslverr_v[0]),
    .hw_we(hw_we_v[0]), .hw_wdata(hw_wdata), .reg_q(regq_v[0]), .wr_pulse(wrp_v[0]));

  apb4_reg_slave #(.WAIT_STATES(3), .PRIV_ONLY(1'b1), .RESET_VAL(RV_B)) u_dut_b (
    .pclk(pclk), .presetn(rst_n[1]), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_v[1]), .prdata(prdata_v[1]), .pslverr(pslverr_v[1]),
    .hw_we(hw_we_v[1]), .hw_wdata(hw_wdata), .reg_q(regq_v[1]), .wr_pulse(wrp_v[1]));

  apb4_reg_slave #(.WAIT_STATES(2), .RESET_VAL(RV_C)) u_dut_c (
    .pclk(pclk), .presetn(rst_n[2]), .paddr(paddr), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .pready(pready_v[2]), .prdata(prdata_v[2]), .pslverr(pslverr_v[2]),
    .hw_we(hw_we_v[2]), .hw_wdata(hw_wdata), .reg_q(regq_v[2]), .wr_pulse(wrp_v[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a falling edge; returns just after the falling edge that
  // follows the completion edge, leaving the bus driven so a new setup can follow.
  task automatic xfer(input int d, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic er, output int wt,
                      output logic [15:0] wp);
    psel = 3'b000; psel[d] = 1'b1;
    paddr = a; pwrite = w; pwdata = wd; pstrb = st; pprot = pr; penable = 1'b0;
    @(negedge pclk); penable = 1'b1; #1;
    wt = 0;
    while (!pready_v[d] && wt < 20) begin
      wt++;
      @(negedge pclk); #1;
    end
    chk("ready", {63'd0, pready_v[d]}, 64'd1);
    rd = prdata_v[d];
    er = pslverr_v[d];
    @(negedge pclk); #1;
    wp = wrp_v[d];
  endtask

  task automatic idle();
    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
    @(negedge pclk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          wt;
    logic [15:0] wp;

    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pstrb = 4'h0; pprot = 3'b001; hw_wdata = '0; rst_n = 3'b000;
    for (int i = 0; i < 3; i++) hw_we_v[i] = '0;
    repeat (3) @(negedge pclk);
    #1;
    chk("rst_pready", {63'd0, pready_v[0]}, 64'd0);
    chk("rst_wrp", {48'd0, wrp_v[0]}, 64'd0);
    chk("rst_prdata", {32'd0, prdata_v[0]}, 64'd0);
    chk("rst_reg0", {32'd0, regq_v[0][31:0]}, 64'h0BADF00D);
    chk("rst_reg5", {32'd0, regq_v[0][5*32 +: 32]}, 64'h5555AAAA);
    chk("rst_c_reg1", {32'd0, regq_v[2][63:32]}, 64'h00C0FFEE);
    rst_n = 3'b111;
    @(negedge pclk); #1;

    // zero-wait write/read
    xfer(0, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, wt, wp);
    chk("wr_waits", 64'(wt), 64'd0);
    chk("wr_err", {63'd0, er}, 64'd0);
    chk("wr_pulse", {48'd0, wp}, 64'h0002);
    idle();
    chk("wr_pulse_off", {48'd0, wrp_v[0]}, 64'd0);
    chk("reg1", {32'd0, regq_v[0][63:32]}, 64'hDEADBEEF);
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, wt, wp);
    chk("rd1", {32'd0, rd}, 64'hDEADBEEF);
    chk("rd1_err", {63'd0, er}, 64'd0);
    idle();

    // byte strobes
    xfer(0, 32'h08, 1'b1, 32'h11223344, 4'hF, 3'b001, rd, er, wt, wp);
    idle();
    xfer(0, 32'h08, 1'b1, 32'hAABBCCDD, 4'h5, 3'b001, rd, er, wt, wp);
    idle();
    chk("reg2_strb", {32'd0, regq_v[0][2*32 +: 32]}, 64'h11BB33DD);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'hF, 3'b001, rd, er, wt, wp);
    chk("rd2_strb_read", {32'd0, rd}, 64'h11BB33DD);
    chk("rd2_strb_err", {63'd0, er}, 64'd0);
    idle();

    // error cases
    xfer(0, 32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, wt, wp);
    chk("oob_err", {63'd0, er}, 64'd1);
    chk("oob_wrp", {48'd0, wp}, 64'd0);
    chk("oob_reg0", {32'd0, regq_v[0][31:0]}, 64'h0BADF00D);
    idle();
    xfer(0, 32'h02, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, wt, wp);
    chk("misal_err", {63'd0, er}, 64'd1);
    chk("misal_wrp", {48'd0, wp}, 64'd0);
    chk("misal_reg0", {32'd0, regq_v[0][31:0]}, 64'h0BADF00D);
    idle();
    xfer(0, 32'h14, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, wt, wp);
    chk("ro_err", {63'd0, er}, 64'd1);
    chk("ro_wrp", {48'd0, wp}, 64'd0);
    chk("ro_reg5", {32'd0, regq_v[0][5*32 +: 32]}, 64'h5555AAAA);
    idle();
    xfer(0, 32'h14, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, wt, wp);
    chk("ro_rd", {32'd0, rd}, 64'h5555AAAA);
    chk("ro_rd_err", {63'd0, er}, 64'd0);
    idle();

    // zero-strobe write
    xfer(0, 32'h04, 1'b1, 32'h00000000, 4'h0, 3'b001, rd, er, wt, wp);
    chk("nostrb_err", {63'd0, er}, 64'd0);
    chk("nostrb_wrp", {48'd0, wp}, 64'h0002);
    chk("nostrb_reg1", {32'd0, regq_v[0][63:32]}, 64'hDEADBEEF);
    idle();

    // aborted transfer
    psel = 3'b001; paddr = 32'h04; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    penable = 1'b0;
    @(negedge pclk); psel = 3'b000;
    @(negedge pclk); #1;
    chk("abort_wrp", {48'd0, wrp_v[0]}, 64'd0);
    chk("abort_reg1", {32'd0, regq_v[0][63:32]}, 64'hDEADBEEF);
    idle();

    // hw update of RO register
    hw_wdata[5*32 +: 32] = 32'h0F0F0F0F;
    hw_we_v[0] = 16'h0020;
    @(negedge pclk); hw_we_v[0] = '0; #1;
    chk("hw_ro_reg5", {32'd0, regq_v[0][5*32 +: 32]}, 64'h0F0F0F0F);

    // same-edge APB and hardware write
    hw_wdata[3*32 +: 32] = 32'h12345678;
    hw_we_v[0] = 16'h0008;
    xfer(0, 32'h0C, 1'b1, 32'h0000BEEF, 4'h3, 3'b001, rd, er, wt, wp);
    hw_we_v[0] = '0;
    chk("merge_reg3", {32'd0, regq_v[0][3*32 +: 32]}, 64'h1234BEEF);
    chk("merge_wrp", {48'd0, wp}, 64'h0008);

    // back-to-back
    xfer(0, 32'h10, 1'b1, 32'h01020304, 4'hF, 3'b001, rd, er, wt, wp);
    chk("b2b_wrp", {48'd0, wp}, 64'h0010);
    xfer(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, wt, wp);
    chk("b2b_rd", {32'd0, rd}, 64'h01020304);
    chk("b2b_waits", 64'(wt), 64'd0);
    idle();

    // three wait states, privilege check
    xfer(1, 32'h00, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, wt, wp);
    chk("ws3_waits", 64'(wt), 64'd3);
    chk("ws3_rd", {32'd0, rd}, 64'hCAFEF00D);
    chk("ws3_err", {63'd0, er}, 64'd0);
    idle();
    xfer(1, 32'h04, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, wt, wp);
    chk("priv_err", {63'd0, er}, 64'd1);
    chk("priv_waits", 64'(wt), 64'd3);
    chk("priv_wrp", {48'd0, wp}, 64'd0);
    chk("priv_reg1", {32'd0, regq_v[1][63:32]}, 64'd0);
    idle();

    // reset during a wait cycle
    psel = 3'b100; paddr = 32'h04; pwrite = 1'b1; pwdata = 32'hDEADBEEF; pstrb = 4'hF;
    pprot = 3'b001; penable = 1'b0;
    @(negedge pclk); penable = 1'b1; #1;
    chk("rstw_pready0", {63'd0, pready_v[2]}, 64'd0);
    rst_n[2] = 1'b0; #1;
    chk("rstw_pready1", {63'd0, pready_v[2]}, 64'd0);
    chk("rstw_prdata", {32'd0, prdata_v[2]}, 64'd0);
    chk("rstw_pslverr", {63'd0, pslverr_v[2]}, 64'd0);
    @(negedge pclk); #1;
    chk("rstw_pready2", {63'd0, pready_v[2]}, 64'd0);
    @(negedge pclk);
    rst_n[2] = 1'b1; psel = 3'b000; penable = 1'b0;
    @(negedge pclk); #1;
    chk("rstw_reg1", {32'd0, regq_v[2][63:32]}, 64'h00C0FFEE);
    chk("rstw_wrp", {48'd0, wrp_v[2]}, 64'd0);
    xfer(2, 32'h04, 1'b0, 32'h0, 4'h0, 3'b001, rd, er, wt, wp);
    chk("rstw_after_waits", 64'(wt), 64'd2);
    chk("rstw_after_rd", {32'd0, rd}, 64'h00C0FFEE);
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/apb4_reg_slave.md
APB4_REG_SLAVE -- requirements
Module: apb4_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 8, 16, 32.
REQ-003 SHALL have parameter NUM_REGS, default 16, register count; power of two, 2..256.
REQ-004 SHALL have parameter WAIT_STATES, default 0, number of pready-low cycles per access, 0..15.
REQ-005 SHALL have parameter RO_MASK, default all-zero, NUM_REGS bits; bit i=1 makes register i read-only from APB.
REQ-006 SHALL have parameter PRIV_ONLY, default 0; 1 makes accesses with pprot[0]=0 error.
REQ-007 SHALL have parameter RESET_VAL, default all-zero, NUM_REGS*DATA_WIDTH bits; register i reset value is slice i.
REQ-008 SHALL have ports:
 pclk  in  1  clock, all logic on rising edge
 presetn  in  1  synchronous active-low reset
 paddr  in  ADDR_WIDTH  byte address
 psel  in  1  slave select
 penable  in  1  access phase
 pwrite  in  1  1=write
 pwdata  in  DATA_WIDTH  write data
 pstrb  in  DATA_WIDTH/8  write byte strobes
 pprot  in  3  protection type
 pready  out  1  transfer complete
 prdata  out  DATA_WIDTH  read data
 pslverr  out  1  transfer error
 hw_we  in  NUM_REGS  hardware update enable per register
 hw_wdata  in  NUM_REGS*DATA_WIDTH  hardware update data
 reg_q  out  NUM_REGS*DATA_WIDTH  current register contents
 wr_pulse  out  NUM_REGS  one-cycle pulse per successful APB write

Function
REQ-009 SHALL implement states IDLE and ACCESS with a 4-bit wait counter.
REQ-010 IDLE: psel=1 and penable=0 SHALL load counter with WAIT_STATES and go to ACCESS; otherwise stay.
REQ-011 ACCESS with psel=1, penable=1: counter!=0 SHALL decrement with pready=0; counter==0 SHALL drive pready=1 that cycle and return to IDLE.
REQ-012 pready SHALL be a function of state and counter only, never of same-cycle inputs beyond psel/penable.
REQ-013 ACCESS with psel=0 (aborted transfer) SHALL return to IDLE with no register update and no wr_pulse.
REQ-014 Index SHALL be paddr[log2(DATA_WIDTH/8) +: log2(NUM_REGS)].
REQ-015 Error SHALL be flagged when paddr >= NUM_REGS*DATA_WIDTH/8, paddr low log2(DATA_WIDTH/8) bits nonzero, write to RO_MASK register, or PRIV_ONLY=1 and pprot[0]=0.
REQ-016 pslverr SHALL equal the error flag while pready=1 and be 0 otherwise.
REQ-017 prdata SHALL equal the indexed register during a read completion (pready=1, pwrite=0, no error), else 0.
REQ-018 Write SHALL commit on the clock edge ending the pready=1 cycle: byte b of register updated iff pstrb[b]=1; error writes SHALL change nothing.
REQ-019 Write with pstrb all-zero SHALL complete without error, change no data, and still pulse wr_pulse.
REQ-020 Read with nonzero pstrb SHALL be ignored, no error.
REQ-021 wr_pulse[i] SHALL be 1 for exactly the cycle after a successful write commit to register i.
REQ-022 hw_we[i]=1 SHALL load hw_wdata slice i into register i on that edge, RO or not.
REQ-023 Same-edge APB commit and hw_we to one register: APB-strobed bytes SHALL take APB data, remaining bytes hw_wdata.
REQ-024 Back-to-back transfers (setup immediately after completion) SHALL be accepted with no idle cycle.

Reset
REQ-025 presetn=0 at a rising edge SHALL force state IDLE, counter 0, registers to RESET_VAL, wr_pulse 0.
REQ-026 During reset pready, prdata, pslverr SHALL be 0; reset mid-ACCESS SHALL drop the transfer with no write.

Verification
REQ-027 WAIT_STATES=0: write 0xDEADBEEF to 0x04, pstrb=0xF -> pready high in first access cycle, reg 1=0xDEADBEEF, wr_pulse[1] one cycle; read 0x04 -> prdata 0xDEADBEEF, pslverr 0.
REQ-028 WAIT_STATES=3: read 0x00 -> pready low 3 access cycles, high on 4th, prdata=RESET_VAL slice 0.
REQ-029 Reg 2 =0x11223344, write 0xAABBCCDD pstrb=0x5 -> reg 2=0x11BB33DD.
REQ-030 Write to 0x40 (NUM_REGS=16), to 0x02, to RO register, and with PRIV_ONLY=1 pprot=0 -> pslverr 1 each, no register change, no wr_pulse.
REQ-031 Same edge: APB writes reg 3 pstrb=0x3 data 0x0000BEEF, hw_we[3] with 0x12345678 -> reg 3=0x1234BEEF.
REQ-032 presetn low during WAIT_STATES=2 write wait cycle -> pready 0, register keeps RESET_VAL, state IDLE after release.
